// File: rtl/vga_modes_pkg.sv
// ----------------------------------------------------------------------------
// vga_modes_pkg
// Purpose : Shared constants for the VGA/DVI timing path. Holds one constant
//           set per supported VESA mode (active/porch/sync widths, polarities,
//           derived totals, nominal pixel clock) and the timing FSM state type.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package vga_modes_pkg;

    typedef struct packed {
        int pclk_khz;
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        int h_pol;
        int v_pol;
        int h_total;
        int v_total;
    } vga_mode_t;

    // Totals are derived here so a mode can never carry inconsistent totals.
    function automatic vga_mode_t mk_mode(input int pclk_khz,
                                          input int ha, input int hfp,
                                          input int hs, input int hbp,
                                          input int va, input int vfp,
                                          input int vs, input int vbp,
                                          input int hp, input int vp);
        vga_mode_t m;
        m.pclk_khz = pclk_khz;
        m.h_active = ha;
        m.h_fp     = hfp;
        m.h_sync   = hs;
        m.h_bp     = hbp;
        m.v_active = va;
        m.v_fp     = vfp;
        m.v_sync   = vs;
        m.v_bp     = vbp;
        m.h_pol    = hp;
        m.v_pol    = vp;
        m.h_total  = ha + hfp + hs + hbp;
        m.v_total  = va + vfp + vs + vbp;
        return m;
    endfunction

    localparam vga_mode_t MODE_640X480  = mk_mode(25175,  640, 16,  96,  48,
                                                  480, 10, 2, 33, 0, 0);
    localparam vga_mode_t MODE_800X600  = mk_mode(40000,  800, 40, 128,  88,
                                                  600,  1, 4, 23, 1, 1);
    localparam vga_mode_t MODE_1024X768 = mk_mode(65000, 1024, 24, 136, 160,
                                                  768,  3, 6, 29, 0, 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vga_state_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_if
// Purpose : Bundles the run control and all timing outputs of vga_timing_gen.
// Signals : run                 - 1 = generate timing, 0 = idle (to generator)
//           x, y [CW]           - undelayed pixel/line counters
//           active, sol, sof    - undelayed active flag, line/frame strobes
//           hsync, vsync, de    - LAT-delayed, polarity-applied sync and DE
//           frame [FW]          - completed-frame count
// Modports: master = timing generator, slave = pixel source / output stage
// ----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CW = 11,
    parameter int FW = 16
);
    logic          run;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          active;
    logic          sol;
    logic          sof;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [FW-1:0] frame;

    modport master (
        input  run,
        output x, y, active, sol, sof, hsync, vsync, de, frame
    );

    modport slave (
        output run,
        input  x, y, active, sol, sof, hsync, vsync, de, frame
    );
endinterface

// File: rtl/vga_timing_gen_sig_delay.sv
// ----------------------------------------------------------------------------
// sig_delay
// Purpose : W-bit wide, LAT-deep shift register with a reset value. LAT=0 is
//           a wire-through.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset (loads RST_VAL everywhere)
//           i_d    - input word
//           o_q    - i_d delayed by LAT clocks
// ----------------------------------------------------------------------------
module sig_delay #(
    parameter int             W       = 1,
    parameter int             LAT     = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (LAT == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [W-1:0] r_pipe [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) r_pipe[i] <= RST_VAL;
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_q = r_pipe[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : Parametrised VESA-style horizontal/vertical timing generator.
//           Counters, strobes and frame count are registered with no added
//           delay; hsync/vsync/de go through a LAT-stage delay so they line up
//           with the pixel source's data, polarity applied at the output.
// Ports   : clk      - pixel clock
//           reset_n  - asynchronous active-low reset (released through a
//                      2-flop synchroniser)
//           bus      - vga_timing_gen_if.master (run in, timing outputs out)
//
// State table
//   state   | meaning
//   ST_IDLE | run=0: x/y held at 0, strobes low, inactive sync/de shifted in
//   ST_RUN  | run=1: counters advance, frame counts completed frames
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_modes_pkg::*;
#(
    parameter int H_ACTIVE = MODE_800X600.h_active,
    parameter int H_FP     = MODE_800X600.h_fp,
    parameter int H_SYNC   = MODE_800X600.h_sync,
    parameter int H_BP     = MODE_800X600.h_bp,
    parameter int V_ACTIVE = MODE_800X600.v_active,
    parameter int V_FP     = MODE_800X600.v_fp,
    parameter int V_SYNC   = MODE_800X600.v_sync,
    parameter int V_BP     = MODE_800X600.v_bp,
    parameter int H_POL    = MODE_800X600.h_pol,
    parameter int V_POL    = MODE_800X600.v_pol,
    parameter int LAT      = 2,
    parameter int CW       = 11,
    parameter int FW       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] C_H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] C_V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] C_HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] C_HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] C_VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] C_VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          C_HS_INV  = (H_POL == 0);
    localparam logic          C_VS_INV  = (V_POL == 0);

    generate
        if ((2**CW) < H_TOTAL || (2**CW) < V_TOTAL) begin : g_chk_cw
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
        if (LAT < 0 || LAT > 15) begin : g_chk_lat
            $error("vga_timing_gen: LAT must be 0..15");
        end
        if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_chk_width
            $error("vga_timing_gen: porch and sync widths must be non-zero");
        end
    endgenerate

    // Reset asserts asynchronously, releases two clocks after reset_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    vga_state_t    r_state;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [FW-1:0] r_frame;
    logic          r_active;
    logic          r_sol;
    logic          r_sof;
    logic [2:0]    r_raw;          // {hsync, vsync, de}, active-high, aligned with x/y

    logic          w_run_nxt;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic [FW-1:0] w_frame_nxt;
    logic [2:0]    w_raw_nxt;
    logic [2:0]    w_dly;

    // Next counter values. Entering RUN (or staying IDLE) lands on the origin,
    // so a frame always starts at x=0,y=0 and a partial frame is never counted.
    always_comb begin
        w_run_nxt   = bus.run;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
        w_frame_nxt = r_frame;
        if (bus.run && r_state == ST_RUN) begin
            if (r_x == C_H_LAST) begin
                if (r_y == C_V_LAST) w_frame_nxt = r_frame + FW'(1);
                else                 w_y_nxt     = r_y + CW'(1);
            end else begin
                w_x_nxt = r_x + CW'(1);
                w_y_nxt = r_y;
            end
        end

        w_raw_nxt = '0;
        if (w_run_nxt) begin
            w_raw_nxt[2] = (w_x_nxt >= C_HS_BEG) && (w_x_nxt < C_HS_END);
            w_raw_nxt[1] = (w_y_nxt >= C_VS_BEG) && (w_y_nxt < C_VS_END);
            w_raw_nxt[0] = (w_x_nxt < C_H_ACT) && (w_y_nxt < C_V_ACT);
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_frame  <= '0;
            r_active <= 1'b0;
            r_sol    <= 1'b0;
            r_sof    <= 1'b0;
            r_raw    <= '0;
        end else begin
            r_state  <= w_run_nxt ? ST_RUN : ST_IDLE;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_frame  <= w_frame_nxt;
            r_active <= w_raw_nxt[0];
            r_sol    <= w_run_nxt && (w_x_nxt == '0);
            r_sof    <= w_run_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
            r_raw    <= w_raw_nxt;
        end
    end

    // r_raw is already the zero-latency registered copy; LAT more stages follow.
    sig_delay #(
        .W       (3),
        .LAT     (LAT),
        .RST_VAL (3'b000)
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (w_rst_n),
        .i_d   (r_raw),
        .o_q   (w_dly)
    );

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.frame  = r_frame;
    assign bus.active = r_active;
    assign bus.sol    = r_sol;
    assign bus.sof    = r_sof;
    assign bus.hsync  = w_dly[2] ^ C_HS_INV;
    assign bus.vsync  = w_dly[1] ^ C_VS_INV;
    assign bus.de     = w_dly[0];

endmodule
